// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: debounced, auto-repeating move requests and a gravity tick for the game FSM
module tetris_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY = 15000000,
  parameter int REPEAT_RATE = 5000000,
  parameter int TICK_CYCLES = 25000000
) (
  input logic CLOCK_50,
  input logic resetn,
  input logic [2:0] key_n,
  input logic drop_sw,
  input logic pause,
  output logic move_valid,
  output logic [1:0] move_code,
  input logic move_ready,
  output logic tick
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW = $clog2(HMAX + 1);
  localparam int GW = $clog2(TICK_CYCLES);
  logic [2:0] s1, s2, deb, deb_d, ev;
  logic [DW-1:0] dcnt [3];
  logic [HW-1:0] hc [1:2];
  logic [2:1] rep_ph, rep_ev;
  logic [1:0] ev_code;
  logic load;
  logic [GW-1:0] gcnt, glast;
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      s1 <= '1;
      s2 <= '1;
      deb <= '1;
      deb_d <= '1;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++)
        if (s2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEBOUNCE_CYCLES)) begin
          deb[i] <= s2[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + DW'(1);
    end
  // hold counter restarts at 1 after each repeat so the next one lands REPEAT_RATE edges later
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      for (int i = 1; i < 3; i++) hc[i] <= '0;
      rep_ph <= '0;
    end else
      for (int i = 1; i < 3; i++)
        if (deb[i]) begin
          hc[i] <= '0;
          rep_ph[i] <= 1'b0;
        end else if (rep_ev[i]) begin
          hc[i] <= HW'(1);
          rep_ph[i] <= 1'b1;
        end else hc[i] <= hc[i] + HW'(1);
  always_comb
    for (int i = 1; i < 3; i++)
      rep_ev[i] = !deb[i] && hc[i] == (rep_ph[i] ? HW'(REPEAT_RATE) : HW'(REPEAT_DELAY));
  assign ev = (deb_d & ~deb) | {rep_ev, 1'b0};
  assign ev_code = ev[0] ? 2'b11 : ev[1] ? 2'b01 : ev[2] ? 2'b10 : 2'b00;
  assign load = !pause && ev_code != 2'b00 && (!move_valid || move_ready);
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      move_valid <= 1'b0;
      move_code <= 2'b00;
    end else if (load) begin
      move_valid <= 1'b1;
      move_code <= ev_code;
    end else if (move_valid && move_ready) begin
      move_valid <= 1'b0;
      move_code <= 2'b00;
    end
  assign glast = drop_sw ? GW'(TICK_CYCLES / 8 - 1) : GW'(TICK_CYCLES - 1);
  assign tick = !pause && gcnt >= glast;
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) gcnt <= '0;
    else if (!pause) gcnt <= tick ? '0 : gcnt + GW'(1);
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb_tetris_input_ctrl: table vectors, hand-written corner sequences and a randomized run against a reference model
module tb_tetris_input_ctrl;
  localparam int DB = 4, RD = 20, RR = 5, TC = 16;
  logic clk = 0, resetn = 1;
  logic [2:0] key_n = '1;
  logic drop_sw = 0, pause = 0, move_ready = 1;
  logic move_valid, tick;
  logic [1:0] move_code;
  int tests = 0, fails = 0, cyc = 0;

  tetris_input_ctrl #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TICK_CYCLES(TC)) dut (
    .CLOCK_50(clk), .resetn(resetn), .key_n(key_n), .drop_sw(drop_sw), .pause(pause),
    .move_valid(move_valid), .move_code(move_code), .move_ready(move_ready), .tick(tick));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] key;
    int len, n, first, last;
    logic [1:0] code;
  } vec_t;
  vec_t vecs[8];

  logic [2:0] m_s1, m_s2, m_deb;
  int m_run[3], m_t[3], m_g;
  logic m_mv;
  logic [1:0] m_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 0;
    key_n = '1;
    drop_sw = 0;
    pause = 0;
    move_ready = 1;
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  task automatic wait_tick(output int at);
    at = -1000;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (tick) begin
        at = cyc;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL tick wait: no tick within 100 cycles");
  endtask

  task automatic model_reset();
    m_s1 = '1;
    m_s2 = '1;
    m_deb = '1;
    m_run = '{0, 0, 0};
    m_t = '{0, 0, 0};
    m_g = 0;
    m_mv = 0;
    m_code = 0;
  endtask

  // A key's event is its press (first cycle debounced low) or, for left/right,
  // each cycle that lies RD + k*RR cycles after that press.
  task automatic model_step(input logic [2:0] k, input logic rdy, input logic pz, input logic drp);
    logic [1:0] code;
    int p;
    code = 0;
    for (int i = 2; i >= 0; i--)
      if (!m_deb[i] && (m_t[i] == 0 || (i != 0 && m_t[i] >= RD && (m_t[i] - RD) % RR == 0)))
        code = (i == 0) ? 2'd3 : 2'(i);
    if (!pz && code != 0 && (!m_mv || rdy)) begin
      m_mv = 1;
      m_code = code;
    end else if (m_mv && rdy) begin
      m_mv = 0;
      m_code = 0;
    end
    p = drp ? TC / 8 : TC;
    if (!pz) m_g = (m_g >= p - 1) ? 0 : m_g + 1;
    for (int i = 0; i < 3; i++)
      if (m_s2[i] != m_deb[i] && m_run[i] == DB) begin
        m_deb[i] = m_s2[i];
        m_run[i] = 0;
        m_t[i] = 0;
      end else begin
        m_run[i] = (m_s2[i] != m_deb[i]) ? m_run[i] + 1 : 0;
        m_t[i]++;
      end
    m_s2 = m_s1;
    m_s1 = k;
  endtask

  initial begin
    int n, first, last, bad, c0, t1, t2, t3, t4, a, b, ptick, idx;
    vecs[0] = '{3'b101, 10, 1, 7, 7, 2'b01};
    vecs[1] = '{3'b101, 3, 0, -1, -1, 2'b00};
    vecs[2] = '{3'b011, 40, 5, 7, 42, 2'b10};
    vecs[3] = '{3'b110, 40, 1, 7, 7, 2'b11};
    vecs[4] = '{3'b101, 30, 3, 7, 32, 2'b01};
    vecs[5] = '{3'b000, 10, 1, 7, 7, 2'b11};
    vecs[6] = '{3'b001, 10, 1, 7, 7, 2'b01};
    vecs[7] = '{3'b101, 5, 1, 7, 7, 2'b01};

    #1 resetn = 0;
    #1;
    check("reset valid", move_valid, 0);
    check("reset code", move_code, 0);
    check("reset tick", tick, 0);

    foreach (vecs[v]) begin
      do_reset();
      key_n = vecs[v].key;
      n = 0; first = -1; last = -1; bad = 0;
      for (int e = 0; e < 60; e++) begin
        @(posedge clk);
        #1;
        if (move_valid) begin
          n++;
          if (first < 0) first = e;
          last = e;
          if (move_code != vecs[v].code) bad++;
        end
        if (e == vecs[v].len - 1) key_n = '1;
      end
      check($sformatf("vec%0d count", v), n, vecs[v].n);
      check($sformatf("vec%0d first edge", v), first, vecs[v].first);
      check($sformatf("vec%0d last edge", v), last, vecs[v].last);
      check($sformatf("vec%0d bad codes", v), bad, 0);
    end

    do_reset();
    move_ready = 0;
    key_n = 3'b110;
    for (int e = 0; e < 45; e++) begin
      @(posedge clk);
      #1;
      if (e == 6) check("hold edge6 valid", move_valid, 0);
      if (e == 7) check("hold edge7 code", {move_valid, move_code}, 3'b111);
      if (e == 9) key_n = '1;
      if (e == 19) key_n = 3'b101;
      if (e == 29) key_n = '1;
    end
    check("hold still pending", {move_valid, move_code}, 3'b111);
    move_ready = 1;
    @(posedge clk);
    #1;
    move_ready = 0;
    check("hold accepted valid", move_valid, 0);
    check("hold accepted code", move_code, 0);
    move_ready = 1;
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (move_valid) n++;
    end
    check("dropped left not queued", n, 0);

    do_reset();
    c0 = cyc;
    wait_tick(t1);
    check("first tick edge", t1 - c0, 15);
    wait_tick(t2);
    check("tick period slow", t2 - t1, 16);
    drop_sw = 1;
    wait_tick(t3);
    wait_tick(t4);
    check("tick period fast", t4 - t3, 2);
    drop_sw = 0;
    repeat (4) @(posedge clk);
    #1;
    check("no tick before switch", tick, 0);
    drop_sw = 1;
    #1;
    check("tick on drop switch", tick, 1);
    @(posedge clk);
    #1;
    check("wrap after drop switch", tick, 0);
    drop_sw = 0;
    wait_tick(a);
    repeat (3) @(posedge clk);
    #1;
    pause = 1;
    ptick = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (tick) ptick++;
    end
    pause = 0;
    check("no tick while paused", ptick, 0);
    wait_tick(b);
    check("tick delayed by pause", b - a, 26);

    do_reset();
    move_ready = 0;
    key_n = 3'b101;
    for (int e = 0; e < 13; e++) begin
      @(posedge clk);
      #1;
      if (e == 7) check("pre-reset valid", move_valid, 1);
    end
    #1 resetn = 0;
    #1;
    check("async reset valid", move_valid, 0);
    check("async reset code", move_code, 0);
    check("async reset tick", tick, 0);
    @(negedge clk);
    resetn = 1;
    move_ready = 1;
    first = -1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (move_valid && first < 0) first = e;
    end
    check("re-press after reset edge", first, 7);
    key_n = '1;

    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      model_step(key_n, move_ready, pause, drop_sw);
      #1;
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, 2);
        key_n[idx] = ~key_n[idx];
      end
      move_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 49) == 0) pause = ~pause;
      if ($urandom_range(0, 39) == 0) drop_sw = ~drop_sw;
      #1;
      check("rand valid", move_valid, m_mv);
      check("rand code", move_code, m_code);
      check("rand tick", tick, !pause && m_g >= (drop_sw ? TC / 8 : TC) - 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
